seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/multdiv_pkg.sv | 32 +++
 rtl/cla_sub33.sv | 71 +++++++
 rtl/seq_divider.sv | 178 +++++++++++++++++
 tb/tb_seq_divider.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_pkg
// Description : Shared widths, iteration count, FSM state encodings and a
//               magnitude helper for the sequential divider.
//               Optional feature macro: DIV_SIGNED_EN (signed operation).
// Revision    : 1.0 - initial release
// ============================================================================
package multdiv_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = 6;
  localparam int ST_W      = 2;

  // Counter value during the final restoring iteration.
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITERS - 1);

  // FSM state encodings.
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
  localparam logic [ST_W-1:0] ST_FIX  = 2'd2;
  localparam logic [ST_W-1:0] ST_DONE = 2'd3;

  // Two's complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude for the most negative value.
  function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] v);
    return v[DIV_WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cla_sub33.sv
`default_nettype none
// ============================================================================
// Module      : cla_sub33
// Description : 33-bit subtractor A + ~B + 1 built from 8-bit carry-lookahead
//               groups with a group-level lookahead carry chain. borrow_o is
//               high when A < B (unsigned).
// Revision    : 1.0 - initial release
// ============================================================================
module cla_sub33 (
  input  logic [32:0] a_i,
  input  logic [32:0] b_i,
  output logic [32:0] diff_o,
  output logic        borrow_o
);

  localparam int W  = 33;
  localparam int GW = 8;
  localparam int NG = (W + GW - 1) / GW;

  logic [NG-1:0] grp_g;
  logic [NG-1:0] grp_p;
  logic [NG:0]   grp_c;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    localparam int LO = k * GW;
    localparam int N  = ((W - LO) < GW) ? (W - LO) : GW;

    logic [N-1:0] bit_g;
    logic [N-1:0] bit_p;
    logic [N-1:0] bit_c;
    logic         gen_acc;
    logic         car_acc;

    assign bit_g = a_i[LO +: N] & ~b_i[LO +: N];
    assign bit_p = a_i[LO +: N] ^ ~b_i[LO +: N];

    // Group generate (carry-out with zero carry-in) and group propagate.
    always_comb begin
      gen_acc = 1'b0;
      for (int i = 0; i < N; i++) begin
        gen_acc = bit_g[i] | (bit_p[i] & gen_acc);
      end
    end
    assign grp_g[k] = gen_acc;
    assign grp_p[k] = &bit_p;

    // In-group carries seeded by the lookahead carry into this group.
    always_comb begin
      bit_c   = '0;
      car_acc = grp_c[k];
      for (int i = 0; i < N; i++) begin
        bit_c[i] = car_acc;
        car_acc  = bit_g[i] | (bit_p[i] & car_acc);
      end
    end

    assign diff_o[LO +: N] = bit_p ^ bit_c;
  end

  // Group-level lookahead; carry-in of 1 completes the two's complement of B.
  always_comb begin
    grp_c[0] = 1'b1;
    for (int k = 0; k < NG; k++) begin
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
    end
  end

  assign borrow_o = ~grp_c[NG];

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : 32-bit sequential restoring divider, one quotient bit per
//               cycle. Divide-by-zero returns all-ones quotient and the
//               dividend as remainder with div_by_zero set.
//               Optional feature macro: DIV_SIGNED_EN adds two's complement
//               operation with a FIX state that applies result signs.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
  import multdiv_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [DIV_WIDTH-1:0] dividend,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic [DIV_WIDTH-1:0] quotient,
  output logic [DIV_WIDTH-1:0] remainder,
  output logic                 busy,
  output logic                 ready,
  output logic                 div_by_zero
);

  logic [ST_W-1:0]      state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] dvd_q, dvd_d;   // dividend bits out, quotient bits in
  logic [DIV_WIDTH-1:0] dvs_q, dvs_d;
  logic [DIV_WIDTH-1:0] rem_q, rem_d;   // partial remainder
  logic [DIV_WIDTH-1:0] quo_q, quo_d;
  logic [DIV_WIDTH-1:0] rmd_q, rmd_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;
  logic                 dbz_q, dbz_d;
`ifdef DIV_SIGNED_EN
  logic                 negq_q, negq_d;
  logic                 negr_q, negr_d;
`endif

  logic [DIV_WIDTH:0]   sub_a;
  logic [DIV_WIDTH:0]   sub_b;
  logic [DIV_WIDTH:0]   sub_diff;
  logic                 sub_borrow;
  logic [DIV_WIDTH-1:0] rem_step;
  logic [DIV_WIDTH-1:0] dvd_step;

  // Shifted partial remainder {rem, next dividend bit} minus the divisor.
  assign sub_a = {rem_q, dvd_q[DIV_WIDTH-1]};
  assign sub_b = {1'b0, dvs_q};

  cla_sub33 u_sub (
    .a_i      (sub_a),
    .b_i      (sub_b),
    .diff_o   (sub_diff),
    .borrow_o (sub_borrow)
  );

  // Restore when the 33-bit difference is negative; quotient bit is ~borrow.
  assign rem_step = sub_diff[DIV_WIDTH] ? sub_a[DIV_WIDTH-1:0] : sub_diff[DIV_WIDTH-1:0];
  assign dvd_step = {dvd_q[DIV_WIDTH-2:0], ~sub_borrow};

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d = ST_DONE;
            quo_d   = '1;
            rmd_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_RUN;
            cnt_d   = '0;
            rem_d   = '0;
            dbz_d   = 1'b0;
`ifdef DIV_SIGNED_EN
            dvd_d   = abs_val(dividend);
            dvs_d   = abs_val(divisor);
            negq_d  = dividend[DIV_WIDTH-1] ^ divisor[DIV_WIDTH-1];
            negr_d  = dividend[DIV_WIDTH-1];
`else
            dvd_d   = dividend;
            dvs_d   = divisor;
`endif
          end
        end
      end
      ST_RUN: begin
        dvd_d = dvd_step;
        rem_d = rem_step;
        if (cnt_q == LAST_ITER) begin
`ifdef DIV_SIGNED_EN
          state_d = ST_FIX;
`else
          state_d = ST_DONE;
          quo_d   = dvd_step;
          rmd_d   = rem_step;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef DIV_SIGNED_EN
      ST_FIX: begin
        state_d = ST_DONE;
        quo_d   = negq_q ? (~dvd_q + 1'b1) : dvd_q;
        rmd_d   = negr_q ? (~rem_q + 1'b1) : rem_q;
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d  = (state_d == ST_RUN) || (state_d == ST_FIX);
    ready_d = (state_d == ST_DONE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
      negq_q  <= negq_d;
      negr_q  <= negr_d;
`endif
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign busy        = busy_q;
  assign ready       = ready_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider: table of directed
//               vectors plus hand sequences for mid-operation reset and a
//               start held high while busy. Honours DIV_SIGNED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

`ifdef DIV_SIGNED_EN
  localparam int LAT = 34;
`else
  localparam int LAT = 33;
`endif
  localparam int NV = 10;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        ready;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[NV];

  seq_divider dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .ready       (ready),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive a start at the negedge; returns 1 time unit after the accepting edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Called just after accepting edge T; sample n is taken between T+n-1 and T+n.
  task automatic wait_ready(input int exp_lat, output int lat, output logic [31:0] q,
                            output logic [31:0] r, output logic dbz, output int busy_bad);
    lat = 0; busy_bad = 0; q = '0; r = '0; dbz = 1'b0;
    for (int n = 1; n <= 60 && lat == 0; n++) begin
      @(negedge clock);
      if (busy !== (n < exp_lat)) busy_bad++;
      if (ready === 1'b1) begin
        lat = n;
        q   = quotient;
        r   = remainder;
        dbz = div_by_zero;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int          lat;
    int          bb;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    launch(v.a, v.b);
    wait_ready(v.lat, lat, q, r, dbz, bb);
    chk({tag, "_latency"}, 32'(lat), 32'(v.lat));
    chk({tag, "_quotient"}, q, v.q);
    chk({tag, "_remainder"}, r, v.r);
    chk({tag, "_dbz"}, {31'd0, dbz}, {31'd0, v.dbz});
    chk({tag, "_busy"}, 32'(bb), 32'd0);
    @(negedge clock);
    chk({tag, "_ready_width"}, {31'd0, ready}, 32'd0);
  endtask

  initial begin : main
    int          lat;
    int          bb;
    int          pulses;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    chk("reset_flags", {29'd0, busy, ready, div_by_zero}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    vecs[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT};
    vecs[1] = '{32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, LAT};
    vecs[2] = '{32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1};
    vecs[3] = '{32'd1000, 32'd1000, 32'd1, 32'd0, 1'b0, LAT};
    vecs[4] = '{32'd3, 32'd10, 32'd0, 32'd3, 1'b0, LAT};
`ifdef DIV_SIGNED_EN
    vecs[5] = '{32'hDEADBEEF, 32'h10, 32'hFDEADBEF, 32'hFFFFFFFF, 1'b0, LAT};
    vecs[6] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, LAT};
    vecs[9] = '{32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, LAT};
`else
    vecs[5] = '{32'hDEADBEEF, 32'h10, 32'h0DEADBEE, 32'h0000000F, 1'b0, LAT};
    vecs[6] = '{32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, LAT};
    vecs[9] = '{32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 1'b0, LAT};
`endif
    vecs[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, LAT};
    vecs[8] = '{32'd12345678, 32'd1000, 32'd12345, 32'd678, 1'b0, LAT};

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset asserted ten cycles into 100 / 7 abandons the operation.
    launch(32'd100, 32'd7);
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    chk("abort_flags", {29'd0, busy, ready, div_by_zero}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (ready === 1'b1) pulses++;
    end
    chk("abort_no_ready", 32'(pulses), 32'd0);
    run_vec('{32'd9, 32'd3, 32'd3, 32'd0, 1'b0, LAT}, "after_abort");

    // Start held high with new operands while busy.
    @(negedge clock);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clock);
    #1;
    dividend = 32'd50;
    divisor  = 32'd5;
    chk("hold_prev_quotient", quotient, 32'd3);
    wait_ready(LAT, lat, q, r, dbz, bb);
    chk("busy_start_latency", 32'(lat), 32'(LAT));
    chk("busy_start_quotient", q, 32'd14);
    chk("busy_start_remainder", r, 32'd2);
    chk("busy_start_busy", 32'(bb), 32'd0);
    @(posedge clock);   // DONE -> IDLE
    @(posedge clock);   // 50 / 5 accepted back-to-back
    #1 start = 1'b0;
    wait_ready(LAT, lat, q, r, dbz, bb);
    chk("b2b_latency", 32'(lat), 32'(LAT));
    chk("b2b_quotient", q, 32'd10);
    chk("b2b_remainder", r, 32'd0);
    chk("b2b_dbz", {31'd0, dbz}, 32'd0);
    repeat (2) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
